pipe_reg: RTL and testbench

Parametrised pipeline stage register for the MIPS datapath: a generalised, flow-controlled successor to the single-bit D flip-flop. It holds one WIDTH-bit payload between two pipeline stages with a valid/ready handshake, a one-entry skid buffer for full throughput under back-pressure, and a synchronous flush for branch/exception squash. It is instantiated between IF/ID, ID/EX, EX/MEM and MEM/WB.

---
 rtl/pipe_reg_if.sv | 24 ++
 rtl/pipe_reg.sv | 96 +++++++++
 tb/tb_pipe_reg.sv | 130 +++++++++++++
 3 files changed

// File: rtl/pipe_reg_if.sv
// Handshake bundle for one pipeline stage: upstream valid/ready/data in,
// downstream valid/ready/data out.
interface pipe_reg_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  // Driver/monitor side: feeds upstream payloads and downstream ready.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  // Stage side: the register itself.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_reg.sv
// Flow-controlled pipeline stage register with a one-entry skid buffer.
// out_valid/in_ready decode from the entry count only, so ready never
// ripples combinationally upstream. flush squashes held entries.
module pipe_reg #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic       clk,
  input  logic       reset,   // synchronous, active low
  input  logic       flush,   // synchronous squash, active high
  pipe_reg_if.slave  bus,
  output logic [1:0] count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic             w_ld_main_in;
  logic             w_ld_main_skid;
  logic             w_ld_skid;

  // State register: reset beats flush beats the handshake.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= EMPTY;
    else        r_state <= w_state_nxt;
  end

  // Next state and data-load strobes; flush discards any incoming payload
  // and leaves the data registers untouched.
  always_comb begin
    w_state_nxt    = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    case (r_state)
      EMPTY: begin
        if (bus.in_valid) begin
          w_ld_main_in = 1'b1;
          w_state_nxt  = ONE;
        end
      end
      ONE: begin
        if (bus.in_valid && bus.out_ready) begin
          w_ld_main_in = 1'b1;
        end else if (bus.in_valid) begin
          w_ld_skid   = 1'b1;
          w_state_nxt = TWO;
        end else if (bus.out_ready) begin
          w_state_nxt = EMPTY;
        end
      end
      TWO: begin
        // in_ready is low here, so in_valid is ignored.
        if (bus.out_ready) begin
          w_ld_main_skid = 1'b1;
          w_state_nxt    = ONE;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
    if (flush) begin
      w_state_nxt    = EMPTY;
      w_ld_main_in   = 1'b0;
      w_ld_main_skid = 1'b0;
      w_ld_skid      = 1'b0;
    end
  end

  // Data registers: main drives out_data, skid absorbs the in-flight word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_main <= RESET_VALUE;
      r_skid <= RESET_VALUE;
    end else begin
      if (w_ld_main_in)        r_main <= bus.in_data;
      else if (w_ld_main_skid) r_main <= r_skid;
      if (w_ld_skid)           r_skid <= bus.in_data;
    end
  end

  // Outputs decoded from state only.
  always_comb begin
    bus.out_valid = (r_state != EMPTY);
    bus.in_ready  = (r_state != TWO);
    bus.out_data  = r_main;
    count         = r_state;
  end

endmodule

// File: tb/tb_pipe_reg.sv
// Self-checking bench for pipe_reg: directed scenarios plus a randomized
// run, all scored against a queue model of the held payloads.
module tb_pipe_reg;
  localparam int          W  = 32;
  localparam logic [31:0] RV = 32'h0;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush;
  logic [1:0] count;

  pipe_reg_if #(.WIDTH(W)) bus ();

  pipe_reg #(.WIDTH(W), .RESET_VALUE(RV)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus),
    .count (count)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] q[$];      // payloads held, front = on out_data
  logic [31:0] m_last;    // what the main register should show

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, let the edge happen, advance the model,
  // then compare everything at the falling edge.
  task automatic step(input logic rst, input logic fl, input logic iv,
                      input logic [31:0] d, input logic ordy);
    logic        acc;
    logic        pre_valid;
    logic [31:0] pre_data;
    reset = rst; flush = fl;
    bus.in_valid = iv; bus.in_data = d; bus.out_ready = ordy;
    pre_valid = bus.out_valid;
    pre_data  = bus.out_data;
    @(posedge clk);
    if (!rst) begin
      q.delete();
      m_last = RV;
    end else if (fl) begin
      q.delete();
    end else begin
      acc = iv && (q.size() < 2);
      if (q.size() > 0 && ordy) void'(q.pop_front());
      if (acc) q.push_back(d);
    end
    if (q.size() > 0) m_last = q[0];
    @(negedge clk);
    chk("count",     64'(count),         64'(q.size()));
    chk("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
    chk("in_ready",  64'(bus.in_ready),  64'(q.size() != 2));
    chk("out_data",  64'(bus.out_data),  64'(m_last));
    if (rst && !fl && pre_valid === 1'b1 && !ordy)
      chk("stall_hold", 64'(bus.out_data), 64'(pre_data));
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    m_last = RV;

    // Reset held two cycles with a payload presented: nothing captured.
    step(0, 0, 1, 32'hDEADBEEF, 0);
    step(0, 0, 1, 32'hDEADBEEF, 0);
    chk("rst_data", 64'(bus.out_data), 64'(RV));
    chk("rst_cnt",  64'(count), 64'd0);
    step(1, 0, 1, 32'hDEADBEEF, 0);
    chk("first_acc", 64'(bus.out_data), 64'h0000_0000_DEAD_BEEF);
    step(1, 0, 0, 0, 1);

    // Streaming 1..8 back to back at full rate.
    for (int i = 1; i <= 8; i++) begin
      step(1, 0, 1, 32'(i), 1);
      chk("stream", 64'(bus.out_data), 64'(i));
      chk("stream_rdy", 64'(bus.in_ready), 64'd1);
    end
    step(1, 0, 0, 0, 1);

    // Back-pressure: 1,2 fill the stage, 3 waits upstream.
    step(1, 0, 1, 32'd1, 0);
    chk("bp_cnt1", 64'(count), 64'd1);
    step(1, 0, 1, 32'd2, 0);
    chk("bp_cnt2", 64'(count), 64'd2);
    step(1, 0, 1, 32'd3, 0);
    chk("bp_hold", 64'(bus.out_data), 64'd1);
    step(1, 0, 1, 32'd3, 1);
    chk("bp_out2", 64'(bus.out_data), 64'd2);
    step(1, 0, 1, 32'd3, 1);
    chk("bp_out3", 64'(bus.out_data), 64'd3);
    step(1, 0, 0, 0, 1);
    chk("bp_empty", 64'(count), 64'd0);

    // Flush with two held and a payload presented: all squashed.
    step(1, 0, 1, 32'hA, 0);
    step(1, 0, 1, 32'hB, 0);
    step(1, 1, 1, 32'hC, 0);
    chk("fl_cnt",   64'(count), 64'd0);
    chk("fl_valid", 64'(bus.out_valid), 64'd0);
    step(1, 0, 0, 0, 1);
    chk("fl_noC", 64'(bus.out_data == 32'hC), 64'd0);

    // Reset mid-stall.
    step(1, 0, 1, 32'h11, 0);
    step(1, 0, 1, 32'h22, 0);
    step(0, 0, 0, 0, 0);
    chk("rs_cnt",  64'(count), 64'd0);
    chk("rs_data", 64'(bus.out_data), 64'(RV));

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 10000; i++) begin
      step(($urandom_range(0, 499) != 0), ($urandom_range(0, 31) == 0),
           1'($urandom), $urandom, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
